// File: rtl/lustre_pkg.sv
// Shared helpers for the Lustre stream blocks: constant clog2 and the common
// register reset value.
package lustre_pkg;

    localparam int LV_RESET_VAL = 0;

    // Smallest r such that 2**r >= value; usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bool_branch_fifo.sv
// One branch buffer of split_bool: a DEPTH-entry FIFO with a registered head
// (no push-to-head bypass) and an occupancy count spanning 0..DEPTH.
module bool_branch_fifo
    import lustre_pkg::*;
#(
    parameter int N     = 7,
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       push,
    input  logic [N:0] push_data,
    output logic       full,
    input  logic       pop,
    output logic [N:0] head,
    output logic       empty
);

    localparam int           AW         = clog2(DEPTH);
    localparam logic [AW:0]  FULL_COUNT = (AW + 1)'(DEPTH);

    logic [N:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            wr_ptr <= AW'(LV_RESET_VAL);
            rd_ptr <= AW'(LV_RESET_VAL);
            count  <= (AW + 1)'(LV_RESET_VAL);
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    // NOTE: storage is deliberately left out of reset; the count alone decides
    // which entries are meaningful, and this lets the array map to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/split_bool.sv
// Boolean-clock stream demultiplexer (Lustre `x when c` / `x when not c`).
// Optional `current` registers per branch are enabled by SPLIT_BOOL_CURRENT_EN.
module split_bool
    import lustre_pkg::*;
#(
    parameter int N     = 7,
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_clock,
    input  logic [N:0] in_data,
    output logic       t_valid,
    input  logic       t_ready,
    output logic [N:0] t_data,
    output logic       f_valid,
    input  logic       f_ready,
    output logic [N:0] f_data
`ifdef SPLIT_BOOL_CURRENT_EN
    ,
    output logic [N:0] t_current,
    output logic [N:0] f_current
`endif
);

    logic t_full, t_empty, t_push, t_pop;
    logic f_full, f_empty, f_push, f_pop;

    // in_ready looks only at the branch selected by in_clock, never at in_valid.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch of
        // the if leaves one unassigned and no latch is inferred.
        in_ready = 1'b0;
        t_push   = 1'b0;
        f_push   = 1'b0;
        if (in_clock) begin
            in_ready = !t_full;
            t_push   = in_valid && !t_full;
        end else begin
            in_ready = !f_full;
            f_push   = in_valid && !f_full;
        end
    end

    assign t_valid = !t_empty;
    assign f_valid = !f_empty;
    assign t_pop   = t_valid && t_ready;
    assign f_pop   = f_valid && f_ready;

    bool_branch_fifo #(.N(N), .DEPTH(DEPTH)) t_fifo (
        .clk       (clk),
        .init_n    (init_n),
        .push      (t_push),
        .push_data (in_data),
        .full      (t_full),
        .pop       (t_pop),
        .head      (t_data),
        .empty     (t_empty)
    );

    bool_branch_fifo #(.N(N), .DEPTH(DEPTH)) f_fifo (
        .clk       (clk),
        .init_n    (init_n),
        .push      (f_push),
        .push_data (in_data),
        .full      (f_full),
        .pop       (f_pop),
        .head      (f_data),
        .empty     (f_empty)
    );

`ifdef SPLIT_BOOL_CURRENT_EN
    // Lustre `current`: hold the last popped word, starting from 0 (0 fby).
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            t_current <= (N + 1)'(LV_RESET_VAL);
            f_current <= (N + 1)'(LV_RESET_VAL);
        end else begin
            if (t_pop) begin
                t_current <= t_data;
            end
            if (f_pop) begin
                f_current <= f_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_split_bool.sv
// Directed self-checking bench for split_bool (N=7, DEPTH=2); the current
// checks are compiled in only when SPLIT_BOOL_CURRENT_EN is defined.
module tb_split_bool;

    logic       clk = 1'b0;
    logic       init_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_clock;
    logic [7:0] in_data;
    logic       t_valid;
    logic       t_ready;
    logic [7:0] t_data;
    logic       f_valid;
    logic       f_ready;
    logic [7:0] f_data;
`ifdef SPLIT_BOOL_CURRENT_EN
    logic [7:0] t_current;
    logic [7:0] f_current;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    split_bool #(.N(7), .DEPTH(2)) dut (
        .clk       (clk),
        .init_n    (init_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_clock  (in_clock),
        .in_data   (in_data),
        .t_valid   (t_valid),
        .t_ready   (t_ready),
        .t_data    (t_data),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .f_data    (f_data)
`ifdef SPLIT_BOOL_CURRENT_EN
        ,
        .t_current (t_current),
        .f_current (f_current)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recv;
        int cyc;
        logic acc;
        logic pop;

        init_n   = 1'b0;
        in_valid = 1'b0;
        in_clock = 1'b0;
        in_data  = 8'h00;
        t_ready  = 1'b0;
        f_ready  = 1'b0;

        // Reset state
        #3;
        check("rst_t_valid", 32'(t_valid), 32'd0);
        check("rst_f_valid", 32'(f_valid), 32'd0);
        in_clock = 1'b1;
        #1;
        check("rst_in_ready_c1", 32'(in_ready), 32'd1);
`ifdef SPLIT_BOOL_CURRENT_EN
        check("rst_t_current", 32'(t_current), 32'd0);
        check("rst_f_current", 32'(f_current), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        init_n = 1'b1;
        tick();

        // Alternating routing with both consumers ready
        t_ready  = 1'b1;
        f_ready  = 1'b1;
        in_valid = 1'b1;
        in_clock = 1'b1;
        in_data  = 8'h01;
        #1;
        check("alt_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_clock = 1'b0;
        in_data  = 8'h02;
        check("alt_t_valid_1", 32'(t_valid), 32'd1);
        check("alt_t_data_01", 32'(t_data), 32'h01);
        check("alt_f_valid_0", 32'(f_valid), 32'd0);
        tick();
        in_clock = 1'b1;
        in_data  = 8'h03;
        check("alt_f_valid_1", 32'(f_valid), 32'd1);
        check("alt_f_data_02", 32'(f_data), 32'h02);
        check("alt_t_drained", 32'(t_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("alt_t_data_03", 32'(t_data), 32'h03);
        check("alt_t_valid_3", 32'(t_valid), 32'd1);
        check("alt_f_drained", 32'(f_valid), 32'd0);
        tick();
        check("alt_t_empty", 32'(t_valid), 32'd0);
`ifdef SPLIT_BOOL_CURRENT_EN
        check("alt_t_current", 32'(t_current), 32'h03);
        check("alt_f_current", 32'(f_current), 32'h02);
`endif

        // Fill the true branch, then switch to the false branch
        t_ready  = 1'b0;
        f_ready  = 1'b0;
        in_valid = 1'b1;
        in_clock = 1'b1;
        in_data  = 8'h11;
        #1;
        check("fill_rdy_1", 32'(in_ready), 32'd1);
        tick();
        in_data = 8'h12;
        #1;
        check("fill_rdy_2", 32'(in_ready), 32'd1);
        tick();
        in_data = 8'h13;
        #1;
        check("fill_rdy_full", 32'(in_ready), 32'd0);
        check("fill_head", 32'(t_data), 32'h11);
        tick();
        check("fill_still_full", 32'(in_ready), 32'd0);
        in_clock = 1'b0;
        in_data  = 8'h21;
        #1;
        check("fill_f_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("fill_f_valid", 32'(f_valid), 32'd1);
        check("fill_f_data", 32'(f_data), 32'h21);

        // Full branch with pop: no bypass, accept next cycle, order kept
        in_valid = 1'b1;
        in_clock = 1'b1;
        in_data  = 8'h13;
        t_ready  = 1'b1;
        #1;
        check("fp_no_bypass", 32'(in_ready), 32'd0);
        check("fp_head_11", 32'(t_data), 32'h11);
        tick();
        check("fp_head_12", 32'(t_data), 32'h12);
        check("fp_rdy_again", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("fp_head_13", 32'(t_data), 32'h13);
        check("fp_valid_13", 32'(t_valid), 32'd1);
        tick();
        check("fp_t_empty", 32'(t_valid), 32'd0);
        t_ready = 1'b0;
        f_ready = 1'b1;
        tick();
        f_ready = 1'b0;
        check("fp_f_empty", 32'(f_valid), 32'd0);
`ifdef SPLIT_BOOL_CURRENT_EN
        check("fp_t_current", 32'(t_current), 32'h13);
        check("fp_f_current", 32'(f_current), 32'h21);
`endif

        // Wrap-around: 20 words on the false branch, consumer toggling
        sent = 0;
        recv = 0;
        cyc  = 0;
        in_clock = 1'b0;
        while (recv < 20 && cyc < 200) begin
            f_ready  = cyc[0];
            in_valid = (sent < 20);
            in_data  = 8'(sent);
            #1;
            acc = in_valid && in_ready;
            pop = f_valid && f_ready;
            if (pop) begin
                check("wrap_data", 32'(f_data), 32'(recv));
                recv++;
            end
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        f_ready  = 1'b0;
        check("wrap_recv_count", 32'(recv), 32'd20);
        check("wrap_sent_count", 32'(sent), 32'd20);
        #1;
        check("wrap_f_empty", 32'(f_valid), 32'd0);

        // Current: pop 14 from true branch, then 05 from false branch
        in_valid = 1'b1;
        in_clock = 1'b1;
        in_data  = 8'h14;
        tick();
        in_clock = 1'b0;
        in_data  = 8'h05;
        tick();
        in_valid = 1'b0;
        check("cur_t_head", 32'(t_data), 32'h14);
        check("cur_f_head", 32'(f_data), 32'h05);
        t_ready = 1'b1;
        tick();
        t_ready = 1'b0;
        check("cur_t_popped", 32'(t_valid), 32'd0);
`ifdef SPLIT_BOOL_CURRENT_EN
        check("cur_t_current", 32'(t_current), 32'h14);
`endif
        f_ready = 1'b1;
        tick();
        f_ready = 1'b0;
        check("cur_f_popped", 32'(f_valid), 32'd0);
`ifdef SPLIT_BOOL_CURRENT_EN
        check("cur_t_hold", 32'(t_current), 32'h14);
        check("cur_f_current", 32'(f_current), 32'h05);
`endif

        // Asynchronous reset between edges with 2 words buffered
        in_valid = 1'b1;
        in_clock = 1'b1;
        in_data  = 8'h31;
        tick();
        in_data = 8'h32;
        tick();
        in_valid = 1'b0;
        check("ar_t_valid_pre", 32'(t_valid), 32'd1);
        check("ar_rdy_pre", 32'(in_ready), 32'd0);
        #2;
        init_n = 1'b0;
        #1;
        check("ar_t_valid", 32'(t_valid), 32'd0);
        check("ar_rdy", 32'(in_ready), 32'd1);
`ifdef SPLIT_BOOL_CURRENT_EN
        check("ar_t_current", 32'(t_current), 32'd0);
`endif
        @(negedge clk);
        init_n = 1'b1;
        tick();
        check("ar_t_valid_post", 32'(t_valid), 32'd0);
        check("ar_f_valid_post", 32'(f_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
